// File: rtl/spi_fifo_pkg.sv
// Shared types and default sizing for the SPI receive word FIFO.
// Imported by the interface, the storage array and the FIFO top.
package spi_fifo_pkg;

    localparam int SPI_WORD_W         = 16;
    localparam int DEFAULT_DEPTH_LOG2 = 4;
    localparam int DEFAULT_DROP_CNT_W = 8;

    typedef logic [SPI_WORD_W-1:0] spi_word_t;

endpackage

// File: rtl/spi_word_fifo_if.sv
// Write-pulse input and valid/ready output stream of the SPI word FIFO.
// master = producer/consumer environment, slave = the FIFO itself.
interface spi_word_fifo_if
    import spi_fifo_pkg::*;
#(
    parameter int WIDTH = SPI_WORD_W
);

    logic             wr_pulse;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output wr_pulse, wr_data, out_ready,
        input  out_data, out_valid
    );

    modport slave (
        input  wr_pulse, wr_data, out_ready,
        output out_data, out_valid
    );

endinterface

// File: rtl/spi_fifo_mem.sv
// Simple dual-port register array: one synchronous write port and one
// asynchronous read port.
module spi_fifo_mem #(
    parameter int WIDTH      = 16,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

    // NOTE: the array has no reset; only the pointers and level define which entries are live.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/spi_word_fifo.sv
// First-word-fall-through FIFO between the SPI receiver and a stallable
// consumer, with sticky overflow flag and saturating dropped-word counter.
module spi_word_fifo
    import spi_fifo_pkg::*;
#(
    parameter int WIDTH      = SPI_WORD_W,
    parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2,
    parameter int DROP_CNT_W = DEFAULT_DROP_CNT_W
) (
    input  logic                  clk,
    input  logic                  reset,
    spi_word_fifo_if.slave        bus,
    input  logic                  clear_ovf,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  full,
    output logic                  overflow,
    output logic [DROP_CNT_W-1:0] drop_count
);

    localparam int                DEPTH      = 2**DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] LEVEL_FULL = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] LEVEL_ONE  = (DEPTH_LOG2+1)'(1);

    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2-1:0] rd_next;
    logic [WIDTH-1:0]      next_head;
    logic [WIDTH-1:0]      head_q;
    logic                  pop;
    logic                  push;
    logic                  drop;

    assign full          = (level == LEVEL_FULL);
    assign bus.out_valid = (level != '0);
    assign bus.out_data  = head_q;

    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign pop     = bus.out_valid & bus.out_ready;
    assign push    = bus.wr_pulse & (~full | pop);
    assign drop    = bus.wr_pulse & full & ~pop;
    assign rd_next = rd_ptr + 1'b1;

    // Reading rd_ptr+1 lets the head register preload the word behind the one being popped.
    spi_fifo_mem #(
        .WIDTH      (WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push & reset),
        .wr_addr (wr_ptr),
        .wr_data (bus.wr_data),
        .rd_addr (rd_next),
        .rd_data (next_head)
    );

    // NOTE: all state uses non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            head_q     <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_next;

            if (push && !pop)      level <= level + 1'b1;
            else if (pop && !push) level <= level - 1'b1;

            // Head only moves on a pop or when the first word lands in an empty FIFO.
            if (pop) begin
                if (level != LEVEL_ONE)  head_q <= next_head;
                else if (push)           head_q <= bus.wr_data;
            end else if (push && level == '0) begin
                head_q <= bus.wr_data;
            end

            if (drop) begin
                overflow <= 1'b1;
                if (clear_ovf)         drop_count <= DROP_CNT_W'(1);
                else if (!(&drop_count)) drop_count <= drop_count + 1'b1;
            end else if (clear_ovf) begin
                overflow   <= 1'b0;
                drop_count <= '0;
            end
        end
    end

endmodule
